// File: rtl/neuron_loader.sv
// neuron_loader: collects N activation/weight beats into registered vectors, captures the neuron result and holds it for downstream
module neuron_loader #(
  parameter int N  = 2,
  parameter int QM = 3,
  parameter int QN = 5,
  parameter int WM = 6,
  parameter int WN = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [QM+QN-1:0]         s_data,
  input  logic [WM+WN-1:0]         s_weight,
  input  logic                     s_last,
  input  logic                     bias_we,
  input  logic [QM+QN-1:0]         bias_in,
  output logic [N*(QM+QN)-1:0]     in_vec,
  output logic [N*(WM+WN)-1:0]     w_vec,
  output logic [QM+QN-1:0]         bias_out,
  input  logic [QM+QN-1:0]         nrn_out,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [QM+QN-1:0]         m_data,
  output logic [15:0]              frame_cnt,
  output logic                     frame_err
);
  localparam int DW = QM + QN;
  localparam int WW = WM + WN;
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {LOAD, CAPTURE, HOLD} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic acc, full, done;
  assign s_ready = state == LOAD && !rst;
  assign acc = s_valid && s_ready;
  assign full = cnt == CW'(N - 1);
  assign done = state == HOLD && m_ready;
  always_comb begin
    state_n = state;
    state_n = state == LOAD ? (acc && full && s_last ? CAPTURE : LOAD) :
              state == CAPTURE ? HOLD : (m_ready ? LOAD : HOLD);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      cnt       <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      in_vec    <= '0;
      w_vec     <= '0;
      bias_out  <= '0;
      frame_cnt <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= !acc ? cnt : (full || s_last) ? '0 : cnt + CW'(1);
      frame_err <= acc && (full != s_last);
      if (acc) begin
        in_vec[int'(cnt)*DW +: DW] <= s_data;
        w_vec[int'(cnt)*WW +: WW]  <= s_weight;
      end
      if (state == CAPTURE) begin
        m_data  <= nrn_out;
        m_valid <= 1'b1;
      end else if (done) m_valid <= 1'b0;
      if (bias_we) bias_out <= bias_in;
      frame_cnt <= frame_cnt + 16'(done);
    end
  end
endmodule

// File: tb/tb_neuron_loader.sv
// tb_neuron_loader: directed vector table plus hand sequences for backpressure, bias timing, reset and counter wrap
module tb_neuron_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0, s_last = 1'b0, bias_we = 1'b0, m_ready = 1'b1;
  logic [7:0] s_data = '0, bias_in = '0, stub = 8'h2A;
  logic [15:0] s_weight = '0;
  logic s_ready, m_valid, frame_err;
  logic [15:0] in_vec, frame_cnt;
  logic [31:0] w_vec;
  logic [7:0] bias_out, nrn_out, m_data;
  int pass = 0, total = 0;
  neuron_loader dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_weight(s_weight), .s_last(s_last), .bias_we(bias_we), .bias_in(bias_in),
    .in_vec(in_vec), .w_vec(w_vec), .bias_out(bias_out), .nrn_out(nrn_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .frame_cnt(frame_cnt),
    .frame_err(frame_err)
  );
  assign nrn_out = stub + bias_out;
  always #5 clk = ~clk;
  typedef struct {
    logic v; logic [7:0] d; logic [15:0] w; logic l; logic mr; logic [7:0] st;
    logic sr; logic mv; logic [7:0] md; logic fe; logic [15:0] fc; logic [15:0] iv; logic [31:0] wv;
  } vec_t;
  vec_t tbl[$];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else pass++;
  endtask
  task automatic beat(input logic [7:0] d, input logic [15:0] w, input logic l);
    s_valid = 1'b1; s_data = d; s_weight = w; s_last = l;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask
  initial begin
    tbl.push_back('{1'b1, 8'h20, 16'h0400, 1'b0, 1'b1, 8'h2A, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0, 16'h0020, 32'h00000400});
    tbl.push_back('{1'b1, 8'h10, 16'h0200, 1'b1, 1'b1, 8'h2A, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 16'h1020, 32'h02000400});
    tbl.push_back('{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 8'h2A, 1'b0, 1'b1, 8'h2A, 1'b0, 16'd0, 16'h1020, 32'h02000400});
    tbl.push_back('{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 8'h2A, 1'b1, 1'b0, 8'h2A, 1'b0, 16'd1, 16'h1020, 32'h02000400});
    tbl.push_back('{1'b1, 8'h55, 16'h1111, 1'b1, 1'b1, 8'h2A, 1'b1, 1'b0, 8'h2A, 1'b1, 16'd1, 16'h1055, 32'h02001111});
    tbl.push_back('{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 8'h2A, 1'b1, 1'b0, 8'h2A, 1'b0, 16'd1, 16'h1055, 32'h02001111});
    tbl.push_back('{1'b1, 8'h33, 16'h0333, 1'b0, 1'b1, 8'h2A, 1'b1, 1'b0, 8'h2A, 1'b0, 16'd1, 16'h1033, 32'h02000333});
    tbl.push_back('{1'b1, 8'h44, 16'h0444, 1'b1, 1'b0, 8'h5C, 1'b0, 1'b0, 8'h2A, 1'b0, 16'd1, 16'h4433, 32'h04440333});
    tbl.push_back('{1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h5C, 1'b0, 1'b1, 8'h5C, 1'b0, 16'd1, 16'h4433, 32'h04440333});
    tbl.push_back('{1'b1, 8'h99, 16'h0999, 1'b1, 1'b0, 8'h77, 1'b0, 1'b1, 8'h5C, 1'b0, 16'd1, 16'h4433, 32'h04440333});
    tbl.push_back('{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 8'h5C, 1'b0, 16'd2, 16'h4433, 32'h04440333});
    tbl.push_back('{1'b1, 8'h01, 16'h0001, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 8'h5C, 1'b0, 16'd2, 16'h4401, 32'h04440001});
    tbl.push_back('{1'b1, 8'h02, 16'h0002, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 8'h5C, 1'b1, 16'd2, 16'h0201, 32'h00020001});
    tbl.push_back('{1'b1, 8'h03, 16'h0003, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 8'h5C, 1'b0, 16'd2, 16'h0203, 32'h00020003});
    tbl.push_back('{1'b1, 8'h04, 16'h0004, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 8'h5C, 1'b0, 16'd2, 16'h0403, 32'h00040003});
    tbl.push_back('{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b0, 16'd2, 16'h0403, 32'h00040003});
    tbl.push_back('{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 8'h11, 1'b0, 16'd3, 16'h0403, 32'h00040003});
    tick();
    tick();
    chk("rst_s_ready", s_ready, 0);
    rst = 1'b0;
    #1;
    chk("rst_vals", {m_valid, m_data, frame_err, frame_cnt, in_vec, bias_out}, 0);
    chk("rst_w_vec", w_vec, 0);
    chk("post_rst_s_ready", s_ready, 1);
    for (int i = 0; i < tbl.size(); i++) begin
      s_valid = tbl[i].v; s_data = tbl[i].d; s_weight = tbl[i].w; s_last = tbl[i].l;
      m_ready = tbl[i].mr; stub = tbl[i].st;
      tick();
      chk($sformatf("v%0d_s_ready", i), s_ready, tbl[i].sr);
      chk($sformatf("v%0d_m_valid", i), m_valid, tbl[i].mv);
      chk($sformatf("v%0d_m_data", i), m_data, tbl[i].md);
      chk($sformatf("v%0d_frame_err", i), frame_err, tbl[i].fe);
      chk($sformatf("v%0d_frame_cnt", i), frame_cnt, tbl[i].fc);
      chk($sformatf("v%0d_in_vec", i), in_vec, tbl[i].iv);
      chk($sformatf("v%0d_w_vec", i), w_vec, tbl[i].wv);
    end
    s_valid = 1'b0; s_last = 1'b0;
    stub = 8'h2A; m_ready = 1'b0;
    beat(8'h20, 16'h0400, 1'b0);
    beat(8'h10, 16'h0200, 1'b1);
    chk("bp_capture_mv", m_valid, 0);
    tick();
    chk("bp_mv", m_valid, 1);
    stub = 8'h00;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      tick();
      chk($sformatf("bp%0d_hold", i), {s_ready, m_valid, m_data}, {1'b0, 1'b1, 8'h2A});
    end
    s_valid = 1'b0; m_ready = 1'b1;
    tick();
    chk("bp_release", {s_ready, m_valid, frame_cnt}, {1'b1, 1'b0, 16'd4});
    chk("bp_in_vec", in_vec, 16'h1020);
    stub = 8'h2A; m_ready = 1'b0;
    beat(8'h01, 16'h0011, 1'b0);
    beat(8'h02, 16'h0022, 1'b1);
    bias_we = 1'b1; bias_in = 8'h08;
    tick();
    bias_we = 1'b0;
    chk("bias_old_capture", m_data, 8'h2A);
    chk("bias_new", bias_out, 8'h08);
    m_ready = 1'b1;
    tick();
    chk("bias_done_cnt", frame_cnt, 16'd5);
    beat(8'h66, 16'h0666, 1'b0);
    chk("rmf_in_vec", in_vec, 16'h0266);
    s_valid = 1'b1; s_data = 8'h77; s_weight = 16'h0777; s_last = 1'b1;
    bias_we = 1'b1; bias_in = 8'h3C; rst = 1'b1;
    tick();
    chk("rmf_vecs", {in_vec, w_vec}, 48'h0);
    chk("rmf_outs", {bias_out, frame_cnt, m_valid, m_data, frame_err}, 0);
    rst = 1'b0; s_valid = 1'b0; s_last = 1'b0; bias_we = 1'b0;
    tick();
    chk("rmf_no_err", {frame_err, s_ready}, 2'b01);
    beat(8'h12, 16'h0012, 1'b0);
    beat(8'h34, 16'h0034, 1'b1);
    chk("rmf_frame", {frame_err, m_valid, in_vec}, {2'b00, 16'h3412});
    tick();
    chk("rmf_result", {m_valid, m_data}, {1'b1, 8'h2A});
    tick();
    chk("rmf_cnt", {m_valid, frame_cnt}, {1'b0, 16'd1});
    tick();
    tick();
    chk("rmf_single", {m_valid, frame_cnt}, {1'b0, 16'd1});
    m_ready = 1'b0;
    beat(8'h05, 16'h0005, 1'b0);
    beat(8'h06, 16'h0006, 1'b1);
    tick();
    force dut.frame_cnt = 16'hFFFF;
    tick();
    release dut.frame_cnt;
    #1;
    chk("wrap_preload", frame_cnt, 16'hFFFF);
    m_ready = 1'b1;
    tick();
    chk("wrap_zero", {m_valid, frame_cnt}, {1'b0, 16'h0000});
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
